// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: branch types, counter encodings, table index helpers.
// Used by both the update scheduler and the fetch-side predictor.
package bp_pkg;

    localparam int unsigned BP_IDX_W  = 10;
    localparam int unsigned BP_HIST_W = 5;
    localparam int unsigned BP_TAG_W  = 10;

    typedef enum logic [1:0] {
        BrOther = 2'b00,
        BrB     = 2'b01,
        BrRet   = 2'b10,
        BrCall  = 2'b11
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b01;
    localparam logic [1:0] CTR_WNT = 2'b00;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRdBht = 2'b01,
        StRdPht = 2'b10,
        StWrite = 2'b11
    } upd_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  br_type;
    } upd_entry_t;

    function automatic logic [BP_IDX_W-1:0] bht_index(input logic [31:0] pc);
        return pc[21:12] ^ pc[11:2];
    endfunction

    function automatic logic [BP_IDX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[11:2];
    endfunction

    function automatic logic [BP_TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[21:12];
    endfunction

    // Saturating 2-bit counter step; the encoding is not a binary count, so walk it explicitly.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        unique case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] restart_pc(input upd_entry_t e);
        return e.taken ? e.target : (e.pc + 32'd4);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-write / one-read FIFO of resolved-branch reports.
// Write port 0 lands ahead of write port 1 when both are enabled.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [1:0]               i_wr_en,
    input  upd_entry_t               i_wr_data0,
    input  upd_entry_t               i_wr_data1,
    input  logic                     i_pop,
    output upd_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    upd_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_n_enq;
    logic [PTR_W-1:0] w_wr_ptr1;

    assign w_n_enq   = CNT_W'(i_wr_en[0]) + CNT_W'(i_wr_en[1]);
    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

    always_ff @(posedge i_clk) begin
        unique case (i_wr_en)
            2'b11: begin
                r_mem[r_wr_ptr]  <= i_wr_data0;
                r_mem[w_wr_ptr1] <= i_wr_data1;
            end
            2'b01:   r_mem[r_wr_ptr] <= i_wr_data0;
            2'b10:   r_mem[r_wr_ptr] <= i_wr_data1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + w_n_enq - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update scheduler: accepts two execute-port reports, redirects fetch on
// mispredict, and serially read-modify-writes BHT/PHT/BTB for every accepted report.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = BP_IDX_W,
    parameter int unsigned HIST_W = BP_HIST_W,
    parameter int unsigned TAG_W  = BP_TAG_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_upd_valid,
    output logic [1:0]        o_upd_ready,
    input  logic [63:0]       i_upd_pc,
    input  logic [63:0]       i_upd_target,
    input  logic [1:0]        i_upd_taken,
    input  logic [3:0]        i_upd_br_type,
    input  logic [1:0]        i_upd_mispred,
    output logic              o_redirect_valid,
    output logic [31:0]       o_redirect_pc,
    output logic [IDX_W-1:0]  o_bht_rd_idx,
    input  logic [HIST_W-1:0] i_bht_rd_data,
    output logic [HIST_W-1:0] o_pht_rd_idx,
    input  logic [1:0]        i_pht_rd_data,
    output logic              o_bht_we,
    output logic [IDX_W-1:0]  o_bht_wr_idx,
    output logic [HIST_W-1:0] o_bht_wr_data,
    output logic              o_pht_we,
    output logic [HIST_W-1:0] o_pht_wr_idx,
    output logic [1:0]        o_pht_wr_data,
    output logic              o_btb_we,
    output logic [IDX_W-1:0]  o_btb_wr_idx,
    output logic [TAG_W-1:0]  o_btb_wr_tag,
    output logic [31:0]       o_btb_wr_target,
    output logic [1:0]        o_btb_wr_type,
    output logic              o_busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    upd_state_e        r_state;
    upd_state_e        w_state_next;
    logic [HIST_W-1:0] r_hist;
    logic [1:0]        r_ctr;
    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic [1:0]        w_acc;
    logic              w_pop;
    logic              w_more;
    logic              w_redir0;
    logic              w_redir1;
    upd_entry_t        w_entry0;
    upd_entry_t        w_entry1;
    upd_entry_t        w_head;

    // Ready depends only on occupancy so the execute stage never sees a valid->ready loop.
    assign w_free      = CNT_W'(DEPTH) - w_count;
    assign o_upd_ready = {w_free >= CNT_W'(2), w_free != '0};
    assign w_acc       = i_upd_valid & o_upd_ready;

    assign w_entry0 = '{pc: i_upd_pc[31:0], target: i_upd_target[31:0],
                        taken: i_upd_taken[0], br_type: i_upd_br_type[1:0]};
    assign w_entry1 = '{pc: i_upd_pc[63:32], target: i_upd_target[63:32],
                        taken: i_upd_taken[1], br_type: i_upd_br_type[3:2]};

    assign w_pop = (r_state == StWrite);

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (w_acc),
        .i_wr_data0 (w_entry0),
        .i_wr_data1 (w_entry1),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign w_redir0 = w_acc[0] & i_upd_mispred[0];
    assign w_redir1 = w_acc[1] & i_upd_mispred[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_redir0 | w_redir1;
            if (w_redir0) begin
                r_redirect_pc <= restart_pc(w_entry0);
            end else if (w_redir1) begin
                r_redirect_pc <= restart_pc(w_entry1);
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

    // Occupancy after this cycle's pop; a same-cycle enqueue also keeps the engine running.
    assign w_more = (w_count > CNT_W'(1)) || (|w_acc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_hist  <= '0;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StRdBht) begin
                r_hist <= i_bht_rd_data;
            end
            if (r_state == StRdPht) begin
                r_ctr <= i_pht_rd_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_count != '0) w_state_next = StRdBht;
            StRdBht: w_state_next = StRdPht;
            StRdPht: w_state_next = StWrite;
            StWrite: w_state_next = w_more ? StRdBht : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_bht_rd_idx    = '0;
        o_pht_rd_idx    = '0;
        o_bht_we        = 1'b0;
        o_bht_wr_idx    = '0;
        o_bht_wr_data   = '0;
        o_pht_we        = 1'b0;
        o_pht_wr_idx    = '0;
        o_pht_wr_data   = '0;
        o_btb_we        = 1'b0;
        o_btb_wr_idx    = '0;
        o_btb_wr_tag    = '0;
        o_btb_wr_target = '0;
        o_btb_wr_type   = '0;
        unique case (r_state)
            StRdBht: o_bht_rd_idx = bht_index(w_head.pc);
            StRdPht: o_pht_rd_idx = r_hist;
            StWrite: begin
                o_pht_we        = 1'b1;
                o_pht_wr_idx    = r_hist;
                o_pht_wr_data   = ctr_next(r_ctr, w_head.taken);
                o_bht_we        = 1'b1;
                o_bht_wr_idx    = bht_index(w_head.pc);
                o_bht_wr_data   = {r_hist[HIST_W-2:0], w_head.taken};
                o_btb_we        = w_head.taken;
                o_btb_wr_idx    = btb_index(w_head.pc);
                o_btb_wr_tag    = btb_tag(w_head.pc);
                o_btb_wr_target = w_head.target;
                o_btb_wr_type   = w_head.br_type;
            end
            default: ;
        endcase
    end

    assign o_busy = (r_state != StIdle) || (w_count != '0);

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: vector table plus hand sequences, with a reference
// table model feeding a write scoreboard and a redirect scoreboard.
module tb_bp_update_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic [1:0]  ty;
        logic        mispred;
    } rpt_t;

    typedef struct packed {
        rpt_t        r;
        logic [31:0] exp_rpc;
    } vec_t;

    typedef struct packed {
        logic [1:0]  we2;
        logic [9:0]  bidx;
        logic [4:0]  bdata;
        logic [4:0]  pidx;
        logic [1:0]  pdata;
        logic        btb_we;
        logic [9:0]  tidx;
        logic [9:0]  tag;
        logic [31:0] tgt;
        logic [1:0]  ty;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  upd_valid;
    logic [1:0]  upd_ready;
    logic [63:0] upd_pc;
    logic [63:0] upd_target;
    logic [1:0]  upd_taken;
    logic [3:0]  upd_br_type;
    logic [1:0]  upd_mispred;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  bht_rd_idx;
    logic [4:0]  bht_rd_data;
    logic [4:0]  pht_rd_idx;
    logic [1:0]  pht_rd_data;
    logic        bht_we;
    logic [9:0]  bht_wr_idx;
    logic [4:0]  bht_wr_data;
    logic        pht_we;
    logic [4:0]  pht_wr_idx;
    logic [1:0]  pht_wr_data;
    logic        btb_we;
    logic [9:0]  btb_wr_idx;
    logic [9:0]  btb_wr_tag;
    logic [31:0] btb_wr_target;
    logic [1:0]  btb_wr_type;
    logic        busy;

    int n_err = 0;
    int n_chk = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];

    logic [4:0]  env_bht [1024];
    logic [1:0]  env_pht [32];
    logic [4:0]  ref_bht [1024];
    logic [1:0]  ref_pht [32];
    logic        clr_tab = 1'b0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .DEPTH  (4),
        .IDX_W  (10),
        .HIST_W (5),
        .TAG_W  (10)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_upd_valid     (upd_valid),
        .o_upd_ready     (upd_ready),
        .i_upd_pc        (upd_pc),
        .i_upd_target    (upd_target),
        .i_upd_taken     (upd_taken),
        .i_upd_br_type   (upd_br_type),
        .i_upd_mispred   (upd_mispred),
        .o_redirect_valid(redirect_valid),
        .o_redirect_pc   (redirect_pc),
        .o_bht_rd_idx    (bht_rd_idx),
        .i_bht_rd_data   (bht_rd_data),
        .o_pht_rd_idx    (pht_rd_idx),
        .i_pht_rd_data   (pht_rd_data),
        .o_bht_we        (bht_we),
        .o_bht_wr_idx    (bht_wr_idx),
        .o_bht_wr_data   (bht_wr_data),
        .o_pht_we        (pht_we),
        .o_pht_wr_idx    (pht_wr_idx),
        .o_pht_wr_data   (pht_wr_data),
        .o_btb_we        (btb_we),
        .o_btb_wr_idx    (btb_wr_idx),
        .o_btb_wr_tag    (btb_wr_tag),
        .o_btb_wr_target (btb_wr_target),
        .o_btb_wr_type   (btb_wr_type),
        .o_busy          (busy)
    );

    // Predictor tables the DUT drives: combinational read, posedge write.
    assign bht_rd_data = env_bht[bht_rd_idx];
    assign pht_rd_data = env_pht[pht_rd_idx];

    always @(posedge clk) begin
        if (clr_tab) begin
            foreach (env_bht[i]) env_bht[i] <= '0;
            foreach (env_pht[i]) env_pht[i] <= '0;
        end else begin
            if (bht_we) env_bht[bht_wr_idx] <= bht_wr_data;
            if (pht_we) env_pht[pht_wr_idx] <= pht_wr_data;
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Counter encoding mapped to a strength level 0..3 and back.
    function automatic logic [1:0] ctr_model(input logic [1:0] c, input logic taken);
        int lvl;
        logic [1:0] enc [4];
        enc[0] = 2'b01; enc[1] = 2'b00; enc[2] = 2'b10; enc[3] = 2'b11;
        lvl = (c == 2'b01) ? 0 : (c == 2'b00) ? 1 : (c == 2'b10) ? 2 : 3;
        if (taken && lvl < 3) lvl++;
        if (!taken && lvl > 0) lvl--;
        return enc[lvl];
    endfunction

    task automatic model_push(input rpt_t r);
        logic [9:0] idx;
        logic [4:0] h;
        logic [1:0] c;
        logic [1:0] nc;
        wr_t e;
        idx = r.pc[21:12] ^ r.pc[11:2];
        h = ref_bht[idx];
        c = ref_pht[h];
        nc = ctr_model(c, r.taken);
        ref_bht[idx] = {h[3:0], r.taken};
        ref_pht[h] = nc;
        e = '0;
        e.we2 = 2'b11;
        e.bidx = idx;
        e.bdata = {h[3:0], r.taken};
        e.pidx = h;
        e.pdata = nc;
        e.btb_we = r.taken;
        if (r.taken) begin
            e.tidx = r.pc[11:2];
            e.tag = r.pc[21:12];
            e.tgt = r.tgt;
            e.ty = r.ty;
        end
        exp_wr.push_back(e);
    endtask

    always @(negedge clk) begin
        wr_t g;
        if (!rst) begin
            if (bht_we || pht_we || btb_we) begin
                g = '0;
                g.we2 = {bht_we, pht_we};
                g.bidx = bht_wr_idx;
                g.bdata = bht_wr_data;
                g.pidx = pht_wr_idx;
                g.pdata = pht_wr_data;
                g.btb_we = btb_we;
                if (btb_we) begin
                    g.tidx = btb_wr_idx;
                    g.tag = btb_wr_tag;
                    g.tgt = btb_wr_target;
                    g.ty = btb_wr_type;
                end
                if (exp_wr.size() == 0) chk("unexpected_write", 128'(g), 128'(0));
                else chk("table_write", 128'(g), 128'(exp_wr.pop_front()));
            end
            if (redirect_valid) begin
                if (exp_redir.size() == 0) chk("unexpected_redirect", 128'(redirect_pc), 128'(1));
                else chk("redirect_pc", 128'(redirect_pc), 128'(exp_redir.pop_front()));
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [1:0] v, input rpt_t r0, input rpt_t r1,
                        input logic [31:0] exp_rpc, output logic [1:0] acc);
        upd_valid   = v;
        upd_pc      = {r1.pc, r0.pc};
        upd_target  = {r1.tgt, r0.tgt};
        upd_taken   = {r1.taken, r0.taken};
        upd_br_type = {r1.ty, r0.ty};
        upd_mispred = {r1.mispred, r0.mispred};
        acc = v & upd_ready;
        if (acc[0]) model_push(r0);
        if (acc[1]) model_push(r1);
        if ((acc[0] && r0.mispred) || (acc[1] && r1.mispred)) exp_redir.push_back(exp_rpc);
        @(posedge clk);
        #1;
        upd_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic send_retry(input rpt_t r);
        logic [1:0] acc;
        int tries;
        acc = 2'b00;
        tries = 0;
        while (!acc[0] && tries < 50) begin
            send(2'b01, r, '0, r.taken ? r.tgt : r.pc + 32'd4, acc);
            tries++;
        end
        if (!acc[0]) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 128'(busy), 128'(0));
    endtask

    task automatic clear_tables();
        clr_tab = 1'b1;
        @(posedge clk);
        #1;
        clr_tab = 1'b0;
        foreach (ref_bht[i]) ref_bht[i] = '0;
        foreach (ref_pht[i]) ref_pht[i] = '0;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] acc;
        rpt_t r0;
        rpt_t r1;
        int lat;

        vecs[0] = '{r: '{pc: 32'h1C000010, tgt: 32'h1C000800, taken: 1'b1, ty: 2'b01, mispred: 1'b0},
                    exp_rpc: 32'h0};
        vecs[1] = '{r: '{pc: 32'hFFFFFFFC, tgt: 32'h12345678, taken: 1'b0, ty: 2'b01, mispred: 1'b1},
                    exp_rpc: 32'h00000000};
        vecs[2] = '{r: '{pc: 32'h00001000, tgt: 32'h00002000, taken: 1'b1, ty: 2'b11, mispred: 1'b1},
                    exp_rpc: 32'h00002000};
        vecs[3] = '{r: '{pc: 32'h00400124, tgt: 32'h00000000, taken: 1'b0, ty: 2'b10, mispred: 1'b1},
                    exp_rpc: 32'h00400128};
        vecs[4] = '{r: '{pc: 32'h80000000, tgt: 32'h80000040, taken: 1'b1, ty: 2'b00, mispred: 1'b0},
                    exp_rpc: 32'h0};

        rst = 1'b1;
        upd_valid = '0; upd_pc = '0; upd_target = '0;
        upd_taken = '0; upd_br_type = '0; upd_mispred = '0;
        clear_tables();
        chk("reset_outputs",
            128'({redirect_valid, redirect_pc, bht_rd_idx, pht_rd_idx, bht_we, bht_wr_idx,
                  bht_wr_data, pht_we, pht_wr_idx, pht_wr_data, btb_we, btb_wr_idx, btb_wr_tag,
                  btb_wr_target, btb_wr_type, busy}), 128'(0));
        chk("reset_ready", 128'(upd_ready), 128'(2'b11));
        rst = 1'b0;
        @(negedge clk);

        // Single taken report: WRITE three cycles after acceptance, busy drops right after.
        send(2'b01, vecs[0].r, '0, 32'h0, acc);
        lat = 0;
        while (!bht_we && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", 128'(lat), 128'(3));
        chk("single_fields", 128'({pht_wr_data, bht_wr_data, btb_we, btb_wr_idx, btb_wr_target}),
            128'({2'b10, 5'b00001, 1'b1, 10'h004, 32'h1C000800}));
        chk("single_busy_write", 128'(busy), 128'(1));
        @(negedge clk);
        chk("single_busy_drop", 128'(busy), 128'(0));

        // Vector table, alternating ports.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) send(2'b01, vecs[i].r, '0, vecs[i].exp_rpc, acc);
            else            send(2'b10, '0, vecs[i].r, vecs[i].exp_rpc, acc);
            chk("vec_accept", 128'(acc != 2'b00), 128'(1));
            wait_idle();
        end

        // Both ports mispredict: one pulse, port 0 target, port 0 applied first.
        r0 = '{pc: 32'h1C0000F0, tgt: 32'h1C000100, taken: 1'b1, ty: 2'b01, mispred: 1'b1};
        r1 = '{pc: 32'h1C000200, tgt: 32'h1C000300, taken: 1'b0, ty: 2'b01, mispred: 1'b1};
        send(2'b11, r0, r1, 32'h1C000100, acc);
        chk("dual_accept", 128'(acc), 128'(2'b11));
        wait_idle();

        // Occupancy and ready encoding.
        r0 = '{pc: 32'h00000200, tgt: 32'h00000300, taken: 1'b1, ty: 2'b01, mispred: 1'b0};
        r1 = '{pc: 32'h00000204, tgt: 32'h00000400, taken: 1'b0, ty: 2'b01, mispred: 1'b0};
        send(2'b11, r0, r1, 32'h0, acc);
        send(2'b01, r1, '0, 32'h0, acc);
        chk("ready_at_depth_m1", 128'(upd_ready), 128'(2'b01));
        send(2'b01, r0, '0, 32'h0, acc);
        chk("ready_full", 128'(upd_ready), 128'(2'b00));
        lat = 0;
        while (!bht_we && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        lat = 0;
        while (!bht_we && lat < 20) begin @(negedge clk); lat++; end
        chk("ready_during_pop", 128'(upd_ready), 128'(2'b01));
        send(2'b01, r0, '0, 32'h0, acc);
        chk("pop_enq_keeps_count", 128'(upd_ready), 128'(2'b01));
        wait_idle();

        // Counter walk on fresh tables, back-to-back same pc.
        clear_tables();
        r0 = '{pc: 32'h00000100, tgt: 32'h00000180, taken: 1'b0, ty: 2'b01, mispred: 1'b0};
        for (int i = 0; i < 3; i++) send_retry(r0);
        r0.taken = 1'b1;
        for (int i = 0; i < 9; i++) send_retry(r0);
        r0.taken = 1'b0;
        for (int i = 0; i < 4; i++) send_retry(r0);
        wait_idle();

        // Reset while in RD_PHT abandons the entry.
        r0 = '{pc: 32'h00000040, tgt: 32'h00000080, taken: 1'b1, ty: 2'b01, mispred: 1'b0};
        send(2'b01, r0, '0, 32'h0, acc);
        lat = 0;
        while (bht_rd_idx != 10'd16 && lat < 20) begin @(negedge clk); lat++; end
        chk("reach_rd_bht", 128'(bht_rd_idx), 128'(10'd16));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs",
            128'({redirect_valid, bht_rd_idx, pht_rd_idx, bht_we, pht_we, btb_we, pht_wr_data,
                  bht_wr_data, busy}), 128'(0));
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b0;
        clear_tables();
        repeat (10) @(negedge clk);
        chk("midreset_empty", 128'({busy, upd_ready}), 128'({1'b0, 2'b11}));

        chk("writes_drained", 128'(exp_wr.size()), 128'(0));
        chk("redirects_drained", 128'(exp_redir.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
